// File: rtl/mac_reg_arbiter.sv
// Round-robin arbiter sharing the single MAC register access port between NUM_REQ requesters.
// Latency: request sampled in IDLE -> o_mac_request next cycle; i_mac_done -> o_req_done next cycle.
// Backpressure: grant held until the engine's done pulse; other requests wait (ignored while busy).
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_req_request/addr/wr_data/rdwn per-requester request level and flattened payload
//   o_req_done, o_req_rd_data      done pulse to the winner only, read data held until next done
//   o_mac_request/addr/wr_data/rdwn registered request towards the MAC register engine
//   i_mac_done, i_mac_rd_data      completion pulse and read data from the engine
//   o_grant, o_busy                one-hot owner (0 when idle) and in-flight flag
//   o_timeout_err                  one-cycle abort pulse
//
// Optional build macro MAC_ARB_TIMEOUT_EN: abort a transaction that sees no i_mac_done
// within TIMEOUT_CYC busy cycles. Without it the arbiter waits for done indefinitely.

module mac_reg_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int IDX_W       = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NUM_REQ-1:0]      i_req_request,
    input  logic [14*NUM_REQ-1:0]   i_req_addr,
    input  logic [32*NUM_REQ-1:0]   i_req_wr_data,
    input  logic [NUM_REQ-1:0]      i_req_rdwn,
    output logic [NUM_REQ-1:0]      o_req_done,
    output logic [31:0]             o_req_rd_data,
    output logic                    o_mac_request,
    output logic [13:0]             o_mac_addr,
    output logic [31:0]             o_mac_wr_data,
    output logic                    o_mac_rdwn,
    input  logic                    i_mac_done,
    input  logic [31:0]             i_mac_rd_data,
    output logic [NUM_REQ-1:0]      o_grant,
    output logic                    o_busy,
    output logic                    o_timeout_err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [NUM_REQ-1:0] ONE_HOT_0 = NUM_REQ'(1);

    logic [1:0]         state;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   win_q;

    // Round-robin pick: lowest requesting index above last_grant, else lowest
    // requesting index overall (the wrap-around). Scanning downward lets the
    // final assignment leave the lowest qualifying index.
    logic               found_hi;
    logic               any_req;
    logic [IDX_W-1:0]   idx_hi;
    logic [IDX_W-1:0]   idx_any;
    logic [IDX_W-1:0]   win_idx;

    always_comb begin
        found_hi = 1'b0;
        any_req  = 1'b0;
        idx_hi   = '0;
        idx_any  = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (i_req_request[j]) begin
                any_req = 1'b1;
                idx_any = IDX_W'(j);
                if (IDX_W'(j) > last_grant) begin
                    found_hi = 1'b1;
                    idx_hi   = IDX_W'(j);
                end
            end
        end
        win_idx = found_hi ? idx_hi : idx_any;
    end

    // Payload of the would-be winner. Only indices below NUM_REQ exist here,
    // so unused upper codes of win_idx can never select anything.
    logic [13:0] sel_addr;
    logic [31:0] sel_wr_data;
    logic        sel_rdwn;

    always_comb begin
        sel_addr    = '0;
        sel_wr_data = '0;
        sel_rdwn    = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (IDX_W'(j) == win_idx) begin
                sel_addr    = i_req_addr[14*j +: 14];
                sel_wr_data = i_req_wr_data[32*j +: 32];
                sel_rdwn    = i_req_rdwn[j];
            end
        end
    end

`ifdef MAC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
    logic [CNT_W-1:0] to_cnt;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign o_timeout_err      = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= ST_IDLE;
            // Pointer at the top index so the first search starts at requester 0.
            last_grant    <= IDX_W'(NUM_REQ - 1);
            win_q         <= '0;
            o_req_done    <= '0;
            o_req_rd_data <= '0;
            o_mac_request <= 1'b0;
            o_mac_addr    <= '0;
            o_mac_wr_data <= '0;
            o_mac_rdwn    <= 1'b0;
            o_grant       <= '0;
            o_busy        <= 1'b0;
`ifdef MAC_ARB_TIMEOUT_EN
            to_cnt        <= '0;
            o_timeout_err <= 1'b0;
`endif
        end else begin
            o_req_done    <= '0;
`ifdef MAC_ARB_TIMEOUT_EN
            o_timeout_err <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        win_q         <= win_idx;
                        o_grant       <= ONE_HOT_0 << win_idx;
                        o_mac_addr    <= sel_addr;
                        o_mac_wr_data <= sel_wr_data;
                        o_mac_rdwn    <= sel_rdwn;
                        o_mac_request <= 1'b1;
                        o_busy        <= 1'b1;
                        state         <= ST_BUSY;
`ifdef MAC_ARB_TIMEOUT_EN
                        to_cnt        <= '0;
`endif
                    end
                end

                ST_BUSY: begin
                    // Done is routed from win_q, not from the live request
                    // bits, so a requester that drops early is still answered.
                    if (i_mac_done) begin
                        o_req_done    <= ONE_HOT_0 << win_q;
                        o_req_rd_data <= i_mac_rd_data;
                        o_mac_request <= 1'b0;
                        o_grant       <= '0;
                        o_busy        <= 1'b0;
                        last_grant    <= win_q;
                        state         <= ST_RELEASE;
                    end
`ifdef MAC_ARB_TIMEOUT_EN
                    else if (to_cnt == CNT_W'(TIMEOUT_CYC)) begin
                        // Same completion as a real done, with a poison read value.
                        o_req_done    <= ONE_HOT_0 << win_q;
                        o_req_rd_data <= TIMEOUT_DATA;
                        o_timeout_err <= 1'b1;
                        o_mac_request <= 1'b0;
                        o_grant       <= '0;
                        o_busy        <= 1'b0;
                        last_grant    <= win_q;
                        state         <= ST_RELEASE;
                    end else begin
                        to_cnt        <= to_cnt + 1'b1;
                    end
`endif
                end

                ST_RELEASE: begin
                    // One dead cycle lets the winner drop its request before
                    // the next arbitration samples the request bits.
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mac_reg_arbiter.md
Name: mac_reg_arbiter

Overview:
Round-robin arbiter that shares the single MAC register access port (MCI request/done engine) between NUM_REQ requesters, e.g. speed poller, PHY register access and host config.
It replaces the static select mux in the speed-control top. It registers the winning requester's address, data and direction, holds the grant until the downstream done pulse, then routes the done pulse and read data back to the winner only.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
IDX_W, 2, width of granted-index field; must satisfy 2**IDX_W >= NUM_REQ
TIMEOUT_CYC, 4096, cycles to wait for i_mac_done before abort (used only with MAC_ARB_TIMEOUT_EN)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_req_request  in  NUM_REQ  per-requester request level, bit k = requester k
i_req_addr  in  14*NUM_REQ  flattened register addresses, slice k = [14k+13:14k]
i_req_wr_data  in  32*NUM_REQ  flattened write data
i_req_rdwn  in  NUM_REQ  1 = read, 0 = write
o_req_done  out  NUM_REQ  one-cycle done pulse to the granted requester
o_req_rd_data  out  32  read data; valid when any o_req_done bit is high
o_mac_request  out  1  request level to the MAC register access engine
o_mac_addr  out  14  registered address
o_mac_wr_data  out  32  registered write data
o_mac_rdwn  out  1  registered direction
i_mac_done  in  1  one-cycle completion pulse from the engine
i_mac_rd_data  in  32  read data, valid with i_mac_done
o_grant  out  NUM_REQ  one-hot current owner; 0 when idle
o_busy  out  1  transaction in flight
o_timeout_err  out  1  one-cycle abort pulse

Behaviour:
- Reset (async, i_rst_n low):
  - All outputs are 0 and the state is IDLE.
  - The round-robin pointer is reset so requester 0 has highest priority.
- Requester contract:
  - Hold request, addr, wr_data and rdwn stable until its done pulse.
  - Drop request in the cycle after done.
- FSM states: IDLE, BUSY, RELEASE.
- IDLE:
  - If any request bit is set, pick the first set bit searching upward from (last_grant+1) mod NUM_REQ, wrapping around.
  - Register that requester's addr, wr_data and rdwn.
  - Set o_grant to the one-hot of the winner and assert o_mac_request and o_busy.
  - Go to BUSY.
  - Latency: request sampled at cycle t gives o_mac_request at t+1.
- BUSY:
  - o_mac_request, o_mac_addr, o_mac_wr_data, o_mac_rdwn and o_grant are held constant.
  - New requests are ignored.
  - If the granted requester drops request mid-transaction, the transaction still completes and done is still pulsed.
  - On i_mac_done at cycle d:
    - At d+1: o_mac_request = 0; o_req_done[winner] = 1 for exactly one cycle; o_req_rd_data = captured i_mac_rd_data.
    - last_grant is updated to the winner and the FSM goes to RELEASE.
- RELEASE:
  - One cycle. No grant is issued, o_grant = 0, o_busy = 0.
  - o_req_rd_data holds its value until the next done.
  - Next state is IDLE, so the earliest next o_mac_request is d+3.
- i_mac_done while in IDLE or RELEASE: ignored, no done pulse generated.
- Simultaneous requests: strict rotation.
  - Example with NUM_REQ=3 and all requesters held high: grant order 0,1,2,0,...
  - No requester waits more than NUM_REQ-1 transactions.
- o_req_done and o_grant are never asserted for a non-granted index.
- Unused upper indices (NUM_REQ < 2**IDX_W) are never granted.

Optional Feature:
MAC_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYC without i_mac_done, the next cycle behaves like a normal done with these differences: o_mac_request = 0; o_req_done[winner] pulses; o_req_rd_data = 32'hDEAD_BEEF; o_timeout_err pulses for one cycle.
  - The FSM then goes to RELEASE.
  - i_mac_done arriving in the same cycle as the timeout wins: normal completion, no error.
- Undefined: the FSM waits in BUSY indefinitely and o_timeout_err is tied to 0.

Test Plan:
- Single read: req1 at addr 14'h0004, rdwn=1; engine returns done with 32'h0000_1140 three cycles later. Required: o_mac_request rises one cycle after the request; o_req_done = 3'b010 one cycle after i_mac_done; o_req_rd_data = 32'h0000_1140.
- All three requesters held high for 6 transactions. Required: grant order 0,1,2,0,1,2; exactly one RELEASE cycle between transactions; o_grant always one-hot or zero.
- Write from req2 (addr 14'h0010, data 32'hA5A5_0001, rdwn=0) while req0 arrives mid-BUSY. Required: o_mac_addr and o_mac_wr_data stay constant until done; req0 is granted only after RELEASE.
- Stray i_mac_done in IDLE. Required: no o_req_done and no state change. Separately, req0 drops its request in BUSY: done is still pulsed to req0.
- Async reset asserted in BUSY. Required: all outputs 0 immediately, no done pulse; after release, req0 has top priority.
- With MAC_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, engine never acks. Required: o_timeout_err pulse and o_req_rd_data = 32'hDEAD_BEEF 17 cycles after grant. A done arriving in the timeout cycle completes normally with no error.
